// File: rtl/ln_fixed_pkg.sv
// Shared constants for the Q24.40 natural-log unit: number format, FSM state type,
// CORDIC repeat schedule and the atanh(2^-i) table generator.
package ln_fixed_pkg;

  localparam int unsigned FRAC_BITS = 40;
  localparam int unsigned ITERS_DEF = 44;
  localparam int unsigned GUARD_DEF = 4;
  localparam int unsigned TAB_LEN   = 64;

  localparam logic signed [63:0] LN2_Q40         = 64'sh0000_00B1_7217_F7D2;
  localparam logic signed [63:0] LN_DOMAIN_VALUE = 64'sh8000_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    NORM        = 3'd1,
    CALL_CORDIC = 3'd2,
    WAIT_CORE   = 3'd3,
    COMBINE     = 3'd4,
    DONE        = 3'd5
  } ln_state_e;

  // Hyperbolic CORDIC only converges if these iterations are executed twice.
  function automatic logic is_repeat(input logic [5:0] i);
    return (i == 6'd4) || (i == 6'd13) || (i == 6'd40);
  endfunction

  // atanh(2^-i) = sum t^(2n+1)/(2n+1), t = 2^-i, summed at 2^-120 resolution and
  // rounded to 'frac' fractional bits. Evaluated only at elaboration.
  function automatic logic [63:0] atanh_q(input int unsigned i, input int unsigned frac);
    logic [127:0] acc;
    int unsigned  e;
    acc = '0;
    if (i == 0) return '0;
    for (int unsigned n = 0; i * (2 * n + 1) <= 120; n++) begin
      e   = 120 - i * (2 * n + 1);
      acc = acc + ((128'd1 << e) / 128'(2 * n + 1));
    end
    acc = acc + (128'd1 << (119 - frac));
    return 64'(acc >> (120 - frac));
  endfunction

endpackage

// File: rtl/cordic_hyp_vectoring.sv
// Iterative hyperbolic CORDIC in vectoring mode: drives Y to zero and accumulates
// Z = atanh(Y0/X0). One iteration per clock; start loads operands, done pulses once.
module cordic_hyp_vectoring
  import ln_fixed_pkg::*;
#(
  parameter int unsigned ITERS = ITERS_DEF,
  parameter int unsigned GUARD = GUARD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [63:0] x0,
  input  logic signed [63:0] y0,
  input  logic signed [63:0] z0,
  output logic               done,
  output logic signed [63:0] z
);

  localparam logic [5:0] LAST_ITER = 6'(ITERS);

  logic [63:0] tab [TAB_LEN];

  for (genvar g = 0; g < TAB_LEN; g++) begin : g_tab
    localparam logic [63:0] ATANH_VAL = atanh_q(g, FRAC_BITS + GUARD);
    assign tab[g] = ATANH_VAL;
  end

  logic signed [63:0] x;
  logic signed [63:0] y;
  logic signed [63:0] x_sh;
  logic signed [63:0] y_sh;
  logic signed [63:0] ang;
  logic [5:0]         iter;
  logic               rep_done;
  logic               busy;
  logic               hold;
  logic               last;

  always_comb begin
    x_sh = x >>> iter;
    y_sh = y >>> iter;
    ang  = signed'(tab[iter]);
    hold = is_repeat(iter) && !rep_done;
    last = (iter == LAST_ITER) && !hold;
  end

  // Rotation direction chosen so that Y shrinks towards zero while Z gathers the angle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      z        <= '0;
      iter     <= 6'd1;
      rep_done <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        x        <= x0;
        y        <= y0;
        z        <= z0;
        iter     <= 6'd1;
        rep_done <= 1'b0;
        busy     <= 1'b1;
      end else if (busy) begin
        if (!y[63]) begin
          x <= x - y_sh;
          y <= y - x_sh;
          z <= z + ang;
        end else begin
          x <= x + y_sh;
          y <= y + x_sh;
          z <= z - ang;
        end
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else if (hold) begin
          rep_done <= 1'b1;
        end else begin
          rep_done <= 1'b0;
          iter     <= iter + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ln_high_precision_wrapper.sv
// Q24.40 natural logarithm: x = 2^k * m, ln(x) = k*ln2 + 2*atanh((m-1)/(m+1)).
// Optional LN_DOMAIN_CHECK_EN flags x <= 0 with domain_err and a sentinel result.
module ln_high_precision_wrapper
  import ln_fixed_pkg::*;
#(
  parameter int unsigned ITERS = ITERS_DEF,
  parameter int unsigned GUARD = GUARD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [63:0] x_in,
  input  logic               x_in_valid,
  output logic               x_in_ready,
  output logic signed [63:0] ln_out,
  output logic               output_valid,
  input  logic               output_ready,
  output logic               domain_err
);

  localparam logic signed [63:0] ONE_Z = 64'sd1 <<< (FRAC_BITS + GUARD);

  ln_state_e          state;
  logic signed [63:0] x_reg;
  logic [63:0]        m_reg;
  logic signed [6:0]  k_reg;
  logic               core_start;
  logic               core_done;
  logic signed [63:0] core_z;

  logic [5:0]         msb;
  logic [63:0]        norm;
  logic signed [6:0]  k_next;
  logic signed [63:0] core_x0;
  logic signed [63:0] core_y0;
  logic signed [63:0] k_wide;
  logic signed [63:0] ln_next;

  always_comb begin
    msb = '0;
    for (int unsigned b = 0; b < 64; b++) begin
      if (x_reg[b]) msb = 6'(b);
    end
    if (msb >= 6'd40) norm = x_reg >> (msb - 6'd40);
    else              norm = x_reg << (6'd40 - msb);
    k_next  = $signed({1'b0, msb}) - 7'sd40;
    core_x0 = signed'(m_reg << GUARD) + ONE_Z;
    core_y0 = signed'(m_reg << GUARD) - ONE_Z;
    k_wide  = {{57{k_reg[6]}}, k_reg};
    ln_next = ((core_z <<< 1) >>> GUARD) + k_wide * LN2_Q40;
  end

  cordic_hyp_vectoring #(
    .ITERS (ITERS),
    .GUARD (GUARD)
  ) u_cordic (
    .clk   (clk),
    .rst_n (rst_n),
    .start (core_start),
    .x0    (core_x0),
    .y0    (core_y0),
    .z0    ('0),
    .done  (core_done),
    .z     (core_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      x_in_ready   <= 1'b0;
      output_valid <= 1'b0;
      ln_out       <= '0;
      x_reg        <= '0;
      m_reg        <= '0;
      k_reg        <= '0;
      core_start   <= 1'b0;
`ifdef LN_DOMAIN_CHECK_EN
      domain_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (x_in_ready && x_in_valid) begin
            x_reg      <= x_in;
            x_in_ready <= 1'b0;
            state      <= NORM;
          end else begin
            x_in_ready <= 1'b1;
          end
        end
        NORM: begin
          m_reg <= norm;
          k_reg <= k_next;
`ifdef LN_DOMAIN_CHECK_EN
          if (x_reg <= 64'sd0) begin
            state <= DONE;
          end else begin
            core_start <= 1'b1;
            state      <= CALL_CORDIC;
          end
`else
          core_start <= 1'b1;
          state      <= CALL_CORDIC;
`endif
        end
        CALL_CORDIC: begin
          core_start <= 1'b0;
          state      <= WAIT_CORE;
        end
        WAIT_CORE: begin
          if (core_done) state <= COMBINE;
        end
        COMBINE: begin
          ln_out       <= ln_next;
          output_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
`ifdef LN_DOMAIN_CHECK_EN
          // Domain errors arrive here with output_valid still low; present the sentinel first.
          if (!output_valid) begin
            ln_out       <= LN_DOMAIN_VALUE;
            domain_err   <= 1'b1;
            output_valid <= 1'b1;
          end else if (output_ready) begin
            output_valid <= 1'b0;
            domain_err   <= 1'b0;
            x_in_ready   <= 1'b1;
            state        <= IDLE;
          end
`else
          if (output_ready) begin
            output_valid <= 1'b0;
            x_in_ready   <= 1'b1;
            state        <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef LN_DOMAIN_CHECK_EN
  assign domain_err = 1'b0;
`endif

endmodule

// File: tb/tb_ln_high_precision_wrapper.sv
// Scoreboard bench for ln_high_precision_wrapper: real-valued ln model, latency and
// handshake checks, output hold, mid-computation reset and optional domain checks.
module tb_ln_high_precision_wrapper;

  localparam int unsigned LAT     = 44 + 3 + 4;
  localparam real         TOL     = 256.0;
  localparam logic signed [63:0] X_ONE  = 64'sh0000_0100_0000_0000;
  localparam logic signed [63:0] X_TWO  = 64'sh0000_0200_0000_0000;
  localparam logic signed [63:0] X_HALF = 64'sh0000_0080_0000_0000;
  localparam logic signed [63:0] X_E    = 64'sh0000_02B7_E151_628A;
  localparam logic signed [63:0] X_MAX  = 64'sh4000_0000_0000_0000;
  localparam logic signed [63:0] X_LSB  = 64'sh0000_0000_0000_0001;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [63:0] x_in = '0;
  logic               x_in_valid = 1'b0;
  logic               x_in_ready;
  logic signed [63:0] ln_out;
  logic               output_valid;
  logic               output_ready = 1'b0;
  logic               domain_err;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned ready_mode = 0;

  typedef struct {
    real         val;
    bit          dom;
    int unsigned acc;
  } exp_t;

  exp_t               exp_q[$];
  exp_t               cur;
  logic               prev_valid = 1'b0;
  logic signed [63:0] held_ln = '0;
  logic               held_dom = 1'b0;
  real                diff;

  ln_high_precision_wrapper dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .x_in         (x_in),
    .x_in_valid   (x_in_valid),
    .x_in_ready   (x_in_ready),
    .ln_out       (ln_out),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .domain_err   (domain_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input bit ok,
                              input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual 0x%016h required 0x%016h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic real ln_model(input logic signed [63:0] v);
    return ($ln(real'(v)) - 40.0 * $ln(2.0)) * (2.0 ** 40);
  endfunction

  function automatic logic signed [63:0] rand_pos();
    int unsigned p;
    logic [63:0] r;
    logic [63:0] one;
    p   = $urandom_range(0, 62);
    r   = {$urandom, $urandom};
    one = 64'd1 << p;
    return signed'((r & (one - 64'd1)) | one);
  endfunction

  always @(negedge clk) begin
    case (ready_mode)
      1:       output_ready = 1'b0;
      2:       output_ready = 1'b1;
      default: output_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (output_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1'b0, ln_out, '0);
        end else begin
          cur = exp_q.pop_front();
          chk("latency", cyc == cur.acc + (cur.dom ? 2 : LAT), 64'(cyc),
              64'(cur.acc + (cur.dom ? 2 : LAT)));
          if (cur.dom) begin
            chk("domain_value", ln_out == 64'sh8000_0000_0000_0000, ln_out,
                64'h8000_0000_0000_0000);
          end else begin
            diff = real'(ln_out) - cur.val;
            if (diff < 0.0) diff = -diff;
            chk("ln_value", diff <= TOL, ln_out, 64'(longint'(cur.val)));
          end
          chk("domain_err", domain_err == cur.dom, 64'(domain_err), 64'(cur.dom));
        end
        held_ln  = ln_out;
        held_dom = domain_err;
      end else if (output_valid) begin
        chk("hold_ln_out", ln_out == held_ln, ln_out, held_ln);
        chk("hold_domain_err", domain_err == held_dom, 64'(domain_err), 64'(held_dom));
        chk("hold_ready_low", x_in_ready == 1'b0, 64'(x_in_ready), 64'd0);
      end
      prev_valid = output_valid;
    end
  end

  task automatic send(input logic signed [63:0] v);
    int unsigned n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!x_in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", x_in_ready == 1'b1, 64'(x_in_ready), 64'd1);
    if (!x_in_ready) return;
    x_in       = v;
    x_in_valid = 1'b1;
    e.acc = cyc + 1;
`ifdef LN_DOMAIN_CHECK_EN
    e.dom = (v <= 64'sd0);
`else
    e.dom = 1'b0;
`endif
    e.val = e.dom ? 0.0 : ln_model(v);
    exp_q.push_back(e);
    @(negedge clk);
    x_in_valid = 1'b0;
    x_in       = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int unsigned n;
    bit ok;
    n = 0;
    while ((exp_q.size() != 0 || output_valid || !x_in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = (exp_q.size() == 0) && !output_valid && x_in_ready;
    chk("drain", ok, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d results outstanding", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    repeat (3) @(negedge clk);
    chk("rst_x_in_ready", x_in_ready == 1'b0, 64'(x_in_ready), 64'd0);
    chk("rst_output_valid", output_valid == 1'b0, 64'(output_valid), 64'd0);
    chk("rst_ln_out", ln_out == 64'sd0, ln_out, 64'd0);
    chk("rst_domain_err", domain_err == 1'b0, 64'(domain_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", x_in_ready == 1'b1, 64'(x_in_ready), 64'd1);

    send(X_ONE);
    send(X_TWO);
    send(X_HALF);
    send(X_E);
    send(X_MAX);
    send(X_LSB);
    for (int i = 0; i < 20; i++) send(rand_pos());
    wait_idle();

    // Output held by downstream back-pressure; a stray x_in_valid must be ignored.
    ready_mode = 1;
    send(X_TWO);
    n = 0;
    while (!output_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reach_done", output_valid == 1'b1, 64'(output_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      x_in_valid = (i == 3);
      x_in       = 64'sh0000_0500_0000_0000;
      @(negedge clk);
    end
    x_in_valid = 1'b0;
    ready_mode = 2;
    n = 0;
    while (output_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("release_valid_low", output_valid == 1'b0, 64'(output_valid), 64'd0);
    chk("release_idle_ready", x_in_ready == 1'b1, 64'(x_in_ready), 64'd1);
    ready_mode = 0;
    wait_idle();

    // Reset in the middle of the CORDIC run.
    send(X_ONE);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_x_in_ready", x_in_ready == 1'b0, 64'(x_in_ready), 64'd0);
    chk("midrst_output_valid", output_valid == 1'b0, 64'(output_valid), 64'd0);
    chk("midrst_ln_out", ln_out == 64'sd0, ln_out, 64'd0);
    chk("midrst_domain_err", domain_err == 1'b0, 64'(domain_err), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(X_ONE);
    wait_idle();

`ifdef LN_DOMAIN_CHECK_EN
    send(64'sd0);
    send(-X_ONE);
    send(X_TWO);
    wait_idle();
`endif

    for (int i = 0; i < 6; i++) send(rand_pos());
    wait_idle();
    chk("queue_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
